// File: rtl/writeback_buffered.sv
// Writeback stage with a 2-entry elastic buffer (head + skid). It drives the register-file
// write port, exposes a forwarding tap per entry and counts retired instructions.
module writeback_buffered #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int PC_W   = 64,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic [REG_AW-1:0] in_dst,
  input  logic [XLEN-1:0]   in_regdata,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              out_ready,
  output logic              wb_valid,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_dst,
  output logic [XLEN-1:0]   wb_data,
  output logic [PC_W-1:0]   wb_pc,
  output logic              fwd0_valid,
  output logic [REG_AW-1:0] fwd0_dst,
  output logic [XLEN-1:0]   fwd0_data,
  output logic              fwd1_valid,
  output logic [REG_AW-1:0] fwd1_dst,
  output logic [XLEN-1:0]   fwd1_data,
  output logic [CNT_W-1:0]  instret
);

  typedef struct packed {
    logic              regwrite;
    logic [REG_AW-1:0] dst;
    logic [XLEN-1:0]   data;
    logic [PC_W-1:0]   pc;
  } entry_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  entry_t in_entry;
  logic   head_valid;
  logic   skid_valid;
  logic   accept;
  logic   load;
  logic   pop;

  assign in_entry = '{regwrite: in_regwrite, dst: in_dst, data: in_regdata, pc: in_pc};

  assign head_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign skid_valid = (state_q == ST_TWO);

  // Ready comes straight from the state register, so out_ready never reaches in_ready.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign pop      = head_valid && out_ready;
  assign load     = accept && !flush;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    skid_d    = skid_q;
    instret_d = instret_q + (pop ? CNT_W'(1) : CNT_W'(0));
    case (state_q)
      ST_EMPTY: begin
        if (load) begin
          head_d  = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (load && pop) begin
          head_d = in_entry;
        end else if (load) begin
          skid_d  = in_entry;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A squash empties the buffer, but a head popping this same cycle has already retired.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      instret_q <= instret_d;
    end
  end

  assign wb_valid = head_valid;
  assign wb_wen   = head_valid && head_q.regwrite && (head_q.dst != '0);
  assign wb_dst   = head_q.dst;
  assign wb_data  = head_q.data;
  assign wb_pc    = head_q.pc;

  assign fwd0_valid = wb_wen;
  assign fwd0_dst   = head_q.dst;
  assign fwd0_data  = head_q.data;

  assign fwd1_valid = skid_valid && skid_q.regwrite && (skid_q.dst != '0);
  assign fwd1_dst   = skid_q.dst;
  assign fwd1_data  = skid_q.data;

  assign instret = instret_q;

endmodule
